// File: rtl/systolic_array_ws_if.sv
// Handshake and data bundle for the weight-stationary systolic array.
// The master side feeds weights and x vectors; the slave side returns y.
interface systolic_array_ws_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 2*DATA_W+$clog2(ARRAY_SIZE)
);
  logic                         w_valid;
  logic [ARRAY_SIZE*DATA_W-1:0] w_row;
  logic                         w_commit;
  logic                         w_full;
  logic                         w_active;
  logic                         in_valid;
  logic [ARRAY_SIZE*DATA_W-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [ARRAY_SIZE*ACC_W-1:0]  out_data;

  modport master (
    output w_valid, w_row, w_commit, in_valid, in_data,
    input  w_full, w_active, in_ready, out_valid, out_data
  );

  modport slave (
    input  w_valid, w_row, w_commit, in_valid, in_data,
    output w_full, w_active, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/systolic_array_ws.sv
// Weight-stationary N x N signed MAC array with skew/de-skew and a
// double-buffered weight store; fixed latency of 2N cycles.
module systolic_array_ws #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 2*DATA_W+$clog2(ARRAY_SIZE)
) (
  input logic          clk,
  input logic          reset,
  systolic_array_ws_if.slave bus
);
  localparam int N  = ARRAY_SIZE;
  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef logic signed [DATA_W-1:0] dat_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  dat_t sh_q [N][N];
  dat_t sh_d [N][N];
  // wt_q[d] is the active tile as it was d cycles ago; PE(r,c) reads
  // delay r+c+1 so in-flight vectors finish on the tile they started with
  dat_t wt_q [2*N][N][N];
  dat_t wt_d [2*N][N][N];
  logic [CW-1:0] cnt_q, cnt_d;
  logic act_q, act_d;
  dat_t xs_q [N][N];
  dat_t xs_d [N][N];
  dat_t xq_q [N][N];
  dat_t xq_d [N][N];
  acc_t pq_q [N][N];
  acc_t pq_d [N][N];
  acc_t ds_q [N][N-1];
  acc_t ds_d [N][N-1];
  logic [2*N-1:0] vld_q, vld_d;
  logic ov_q, ov_d;
  logic [N*ACC_W-1:0] od_q, od_d;

  logic accept;
  logic commit;
  dat_t x_in;
  acc_t p_in;

  always_comb begin
    accept = bus.in_valid && act_q;
    commit = bus.w_commit && (cnt_q == FULL);
    x_in   = '0;
    p_in   = '0;

    sh_d = sh_q;
    if (bus.w_valid) begin
      for (int i = N-1; i > 0; i--) sh_d[i] = sh_q[i-1];
      for (int c = 0; c < N; c++)
        sh_d[0][c] = bus.w_row[c*DATA_W +: DATA_W];
    end

    cnt_d = cnt_q;
    if (commit)
      cnt_d = bus.w_valid ? CW'(1) : '0;
    else if (bus.w_valid && cnt_q != FULL)
      cnt_d = cnt_q + 1'b1;
    act_d = act_q | commit;

    wt_d[0] = wt_q[0];
    if (commit) wt_d[0] = sh_q;
    for (int d = 1; d < 2*N; d++) wt_d[d] = wt_q[d-1];

    for (int r = 0; r < N; r++) begin
      xs_d[r][0] = accept ? dat_t'(bus.in_data[r*DATA_W +: DATA_W]) : '0;
      for (int j = 1; j < N; j++) xs_d[r][j] = xs_q[r][j-1];
    end

    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        x_in = (c == 0) ? xs_q[r][r] : xq_q[r][c-1];
        p_in = (r == 0) ? '0 : pq_q[r-1][c];
        xq_d[r][c] = x_in;
        pq_d[r][c] = p_in + acc_t'(x_in) * acc_t'(wt_q[r+c+1][r][c]);
      end
    end

    for (int c = 0; c < N; c++) begin
      ds_d[c][0] = pq_q[N-1][c];
      for (int j = 1; j < N-1; j++) ds_d[c][j] = ds_q[c][j-1];
    end

    vld_d = {vld_q[2*N-2:0], accept};
    ov_d  = vld_q[2*N-1];
    od_d  = od_q;
    if (vld_q[2*N-1]) begin
      for (int c = 0; c < N-1; c++)
        od_d[c*ACC_W +: ACC_W] = ds_q[c][N-2-c];
      od_d[(N-1)*ACC_W +: ACC_W] = pq_q[N-1][N-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '{default: '0};
      wt_q  <= '{default: '0};
      cnt_q <= '0;
      act_q <= 1'b0;
      xs_q  <= '{default: '0};
      xq_q  <= '{default: '0};
      pq_q  <= '{default: '0};
      ds_q  <= '{default: '0};
      vld_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
    end else begin
      sh_q  <= sh_d;
      wt_q  <= wt_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      xs_q  <= xs_d;
      xq_q  <= xq_d;
      pq_q  <= pq_d;
      ds_q  <= ds_d;
      vld_q <= vld_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
    end
  end

  assign bus.w_full    = (cnt_q == FULL);
  assign bus.w_active  = act_q;
  assign bus.in_ready  = act_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
endmodule
